// File: rtl/polyphase_fir_mac.sv
// ----------------------------------------------------------------------------
// polyphase_fir_mac
//
// Polyphase FIR multiply-accumulate stage of the sample-rate converter. Takes
// one 4-sample window per stream over a req/ack handshake. It then multiplies
// the window by the 4-tap coefficient set of the current polyphase index. One
// multiplier is shared over 4 cycles. The sum is rounded half-up and saturated
// to DWIDTH, and the result is offered downstream with the same req/ack
// handshake.
//
// Ports:
//   clk         clock, all logic on posedge
//   rst         synchronous active-low reset
//   enable      high = run, low = freeze every register (incl. coefficient RAM)
//   req_in      block ready to accept a window
//   ack_in      upstream presents a window; transfer on req_in && ack_in
//   data_in     4 samples, sample k at bits [k*DWIDTH +: DWIDTH], k=0 newest
//   stream_in   stream index of the window
//   req_out     result valid
//   ack_out     downstream takes result; transfer on req_out && ack_out
//   data_out    filtered sample
//   stream_out  stream index of data_out
//   coef_we     coefficient write strobe (honoured only while idle)
//   coef_addr   coefficient address = phase*4 + tap
//   coef_data   coefficient value, Q1.(DWIDTH-1)
// ----------------------------------------------------------------------------
module polyphase_fir_mac #(
    parameter int unsigned DWIDTH         = 16,
    parameter int unsigned DDWIDTH        = 2 * DWIDTH,
    parameter int unsigned NR_STREAMS     = 16,
    parameter int unsigned NR_STREAMS_LOG = 4,
    parameter int unsigned L              = 3,
    parameter int unsigned COEF_ADDR_BITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    output logic                      req_in,
    input  logic                      ack_in,
    input  logic [0:4*DWIDTH-1]       data_in,
    input  logic [NR_STREAMS_LOG-1:0] stream_in,
    output logic                      req_out,
    input  logic                      ack_out,
    output logic [0:DWIDTH-1]         data_out,
    output logic [NR_STREAMS_LOG-1:0] stream_out,
    input  logic                      coef_we,
    input  logic [COEF_ADDR_BITS-1:0] coef_addr,
    input  logic [DWIDTH-1:0]         coef_data
);

    localparam int unsigned AccW    = DDWIDTH + 2;
    localparam int unsigned NrCoef  = 2 ** COEF_ADDR_BITS;
    localparam int unsigned NrUsed  = 4 * L;
    localparam int unsigned PhaseW  = (L > 1) ? $clog2(L) : 1;

    localparam logic signed [AccW-1:0] RoundK = AccW'(1) << (DWIDTH - 2);
    localparam logic signed [AccW-1:0] SatMax =
        {{(AccW - DWIDTH + 1){1'b0}}, {(DWIDTH - 1){1'b1}}};
    localparam logic signed [AccW-1:0] SatMin =
        {{(AccW - DWIDTH + 1){1'b1}}, {(DWIDTH - 1){1'b0}}};

    localparam logic [NR_STREAMS_LOG-1:0] LastStream = NR_STREAMS_LOG'(NR_STREAMS - 1);
    localparam logic [PhaseW-1:0]         LastPhase  = PhaseW'(L - 1);

    typedef enum logic [1:0] {StIdle, StMac, StRound, StOut} state_e;

    state_e                      state_q;
    logic                        req_in_q;
    logic                        req_out_q;
    logic [DWIDTH-1:0]           data_out_q;
    logic [NR_STREAMS_LOG-1:0]   stream_out_q;
    logic [NR_STREAMS_LOG-1:0]   stream_q;
    logic [PhaseW-1:0]           phase_q;
    logic [PhaseW-1:0]           cur_phase_q;   // phase latched at accept
    logic [1:0]                  tap_q;
    logic signed [AccW-1:0]      acc_q;
    logic signed [DWIDTH-1:0]    samp_q [4];

    // Coefficient RAM, deliberately not cleared by reset.
    logic signed [DWIDTH-1:0]    coef_mem [NrCoef];

    logic [COEF_ADDR_BITS-1:0]   coef_rd_addr;
    logic signed [DDWIDTH-1:0]   prod;
    logic signed [AccW-1:0]      acc_rnd;
    logic signed [AccW-1:0]      acc_shr;
    logic [DWIDTH-1:0]           sat_val;

    // {phase, tap} is phase*4 + tap.
    assign coef_rd_addr = COEF_ADDR_BITS'({cur_phase_q, tap_q});

    always_comb begin
        prod    = DDWIDTH'(samp_q[tap_q]) * DDWIDTH'(coef_mem[coef_rd_addr]);
        acc_rnd = acc_q + RoundK;
        acc_shr = acc_rnd >>> (DWIDTH - 1);
        sat_val = acc_shr[DWIDTH-1:0];
        if (acc_shr > SatMax) begin
            sat_val = SatMax[DWIDTH-1:0];
        end else if (acc_shr < SatMin) begin
            sat_val = SatMin[DWIDTH-1:0];
        end
    end

    // Writes land only while idle so an in-flight window sees a stable set.
    always_ff @(posedge clk) begin
        if (rst && enable && coef_we && (state_q == StIdle) && (32'(coef_addr) < NrUsed)) begin
            coef_mem[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            req_in_q     <= 1'b0;
            req_out_q    <= 1'b0;
            data_out_q   <= '0;
            stream_out_q <= '0;
            stream_q     <= '0;
            phase_q      <= '0;
            cur_phase_q  <= '0;
            tap_q        <= '0;
            acc_q        <= '0;
            for (int k = 0; k < 4; k++) begin
                samp_q[k] <= '0;
            end
        end else if (enable) begin
            case (state_q)
                StIdle: begin
                    if (req_in_q && ack_in) begin
                        for (int k = 0; k < 4; k++) begin
                            samp_q[k] <= data_in[k*DWIDTH +: DWIDTH];
                        end
                        stream_q    <= stream_in;
                        cur_phase_q <= phase_q;
                        acc_q       <= '0;
                        tap_q       <= '0;
                        req_in_q    <= 1'b0;
                        state_q     <= StMac;
                    end else begin
                        req_in_q <= 1'b1;
                    end
                end
                StMac: begin
                    acc_q <= acc_q + AccW'(prod);
                    tap_q <= tap_q + 2'd1;
                    if (tap_q == 2'd3) begin
                        state_q <= StRound;
                    end
                end
                StRound: begin
                    data_out_q   <= sat_val;
                    stream_out_q <= stream_q;
                    req_out_q    <= 1'b1;
                    state_q      <= StOut;
                end
                StOut: begin
                    if (ack_out) begin
                        req_out_q <= 1'b0;
                        req_in_q  <= 1'b1;
                        state_q   <= StIdle;
                        // A round ends when the last stream is handed off.
                        if (stream_out_q == LastStream) begin
                            phase_q <= (phase_q == LastPhase) ? '0 : phase_q + PhaseW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_in     = req_in_q;
    assign req_out    = req_out_q;
    assign data_out   = data_out_q;
    assign stream_out = stream_out_q;

endmodule

// File: tb/tb_polyphase_fir_mac.sv
module tb_polyphase_fir_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        req_in;
    logic        ack_in;
    logic [0:63] data_in;
    logic [3:0]  stream_in;
    logic        req_out;
    logic        ack_out;
    logic [0:15] data_out;
    logic [3:0]  stream_out;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [15:0] coef_data;

    int n_assert = 0;
    int n_fail   = 0;
    int ph       = 0;   // expected polyphase index
    logic [19:0] sb_q [$];  // {stream, data}

    polyphase_fir_mac dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .req_in     (req_in),
        .ack_in     (ack_in),
        .data_in    (data_in),
        .stream_in  (stream_in),
        .req_out    (req_out),
        .ack_out    (ack_out),
        .data_out   (data_out),
        .stream_out (stream_out),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Output for a 4 x 0x1000 window in each phase (coefs 0x4000 / 0 / 0x2000).
    function automatic logic [15:0] exp_for(input int p);
        case (p)
            0:       return 16'h2000;
            1:       return 16'h0000;
            default: return 16'h1000;
        endcase
    endfunction

    task automatic wr_coef(input logic [3:0] a, input logic [15:0] d);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic wr_set(input int p, input logic [15:0] c0, c1, c2, c3);
        wr_coef(4'(p * 4 + 0), c0);
        wr_coef(4'(p * 4 + 1), c1);
        wr_coef(4'(p * 4 + 2), c2);
        wr_coef(4'(p * 4 + 3), c3);
    endtask

    // Present a window and return right after its accept edge.
    task automatic do_window(input logic [15:0] s0, s1, s2, s3, input logic [3:0] strm,
                             input logic [15:0] exp, input bit push);
        int i;
        for (i = 0; i < 50 && req_in !== 1'b1; i++) @(negedge clk);
        chk("req_in_ready", {31'd0, req_in}, 32'd1);
        if (push) sb_q.push_back({strm, exp});
        data_in = {s0, s1, s2, s3}; stream_in = strm; ack_in = 1'b1;
        @(negedge clk);
        ack_in = 1'b0;
    endtask

    // Wait for a result, optionally stall ack_out, compare against the scoreboard, ack.
    task automatic get_result(input string tag, input int hold);
        int i;
        logic [19:0] e;
        logic [15:0] d0;
        bit ok;
        for (i = 0; i < 50 && req_out !== 1'b1; i++) @(negedge clk);
        chk({tag, "_req_out"}, {31'd0, req_out}, 32'd1);
        d0 = data_out;
        ok = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (data_out !== d0 || req_in !== 1'b0 || req_out !== 1'b1) ok = 1'b0;
        end
        if (hold > 0) chk({tag, "_stall_stable"}, {31'd0, ok}, 32'd1);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_data"}, {16'd0, data_out}, {16'd0, e[15:0]});
            chk({tag, "_stream"}, {28'd0, stream_out}, {28'd0, e[19:16]});
            if (e[19:16] == 4'd15) ph = (ph + 1) % 3;
        end
        ack_out = 1'b1;
        @(negedge clk);
        ack_out = 1'b0;
    endtask

    initial begin
        int cnt;
        bit ok;
        rst = 1'b0; enable = 1'b1; ack_in = 1'b0; ack_out = 1'b0;
        data_in = '0; stream_in = '0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_in", {31'd0, req_in}, 32'd0);
        chk("rst_req_out", {31'd0, req_out}, 32'd0);
        chk("rst_data_out", {16'd0, data_out}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("release_req_in", {31'd0, req_in}, 32'd1);

        wr_set(0, 16'h4000, 16'h4000, 16'h4000, 16'h4000);
        wr_set(1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        wr_set(2, 16'h2000, 16'h2000, 16'h2000, 16'h2000);

        // Latency with ack_out held high
        ack_out = 1'b1;
        sb_q.push_back({4'd3, 16'h2000});
        data_in = {4{16'h1000}}; stream_in = 4'd3; ack_in = 1'b1;
        @(negedge clk);
        ack_in = 1'b0;
        chk("accept_drops_req_in", {31'd0, req_in}, 32'd0);
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (req_out !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        chk("no_early_req_out", {31'd0, ok}, 32'd1);
        chk("req_out_after_e5", {31'd0, req_out}, 32'd1);
        begin
            logic [19:0] e;
            e = sb_q.pop_front();
            chk("lat_data", {16'd0, data_out}, {16'd0, e[15:0]});
            chk("lat_stream", {28'd0, stream_out}, {28'd0, e[19:16]});
        end
        @(negedge clk);
        ack_out = 1'b0;
        chk("lat_req_out_clr", {31'd0, req_out}, 32'd0);
        chk("lat_req_in_back", {31'd0, req_in}, 32'd1);

        // Rounding
        wr_set(0, 16'h4000, 16'h0000, 16'h0000, 16'h0000);
        do_window(16'h0001, 16'h0000, 16'h0000, 16'h0000, 4'd1, 16'h0001, 1'b1);
        get_result("round_pos", 0);
        do_window(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 4'd1, 16'h0000, 1'b1);
        get_result("round_neg", 0);

        // Mixed taps: 0x400000 - 0x800000 + 0x800000 + 0x7FFF -> 0x0081
        wr_set(0, 16'h4000, 16'hC000, 16'h2000, 16'h7FFF);
        do_window(16'h0100, 16'h0200, 16'h0400, 16'h0001, 4'd2, 16'h0081, 1'b1);
        get_result("mixed", 0);

        // Saturation
        wr_set(0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        do_window(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 4'd4, 16'h7FFF, 1'b1);
        get_result("sat_pos", 0);
        do_window(16'h8000, 16'h8000, 16'h8000, 16'h8000, 4'd5, 16'h8000, 1'b1);
        get_result("sat_neg", 0);

        // Phase advance over three full rounds, then back to phase 0
        wr_set(0, 16'h4000, 16'h4000, 16'h4000, 16'h4000);
        for (int r = 0; r < 3; r++) begin
            for (int s = 0; s < 16; s++) begin
                do_window(16'h1000, 16'h1000, 16'h1000, 16'h1000, 4'(s), exp_for(ph), 1'b1);
                get_result($sformatf("phase%0d_s%0d", ph, s), 0);
            end
        end
        do_window(16'h1000, 16'h1000, 16'h1000, 16'h1000, 4'd15, exp_for(ph), 1'b1);
        get_result("phase_wrap", 0);

        // Reset mid-MAC while in phase 1: aborted, phase back to 0, coefs kept
        do_window(16'h1000, 16'h1000, 16'h1000, 16'h1000, 4'd6, 16'h0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        ph = 0;
        ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (req_out !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        chk("abort_no_req_out", {31'd0, ok}, 32'd1);
        chk("abort_data_out", {16'd0, data_out}, 32'd0);
        do_window(16'h1000, 16'h1000, 16'h1000, 16'h1000, 4'd0, exp_for(ph), 1'b1);
        get_result("after_abort", 0);

        // Downstream stall for 10 cycles
        do_window(16'h1000, 16'h1000, 16'h1000, 16'h1000, 4'd7, 16'h2000, 1'b1);
        get_result("stall", 10);

        // enable low for 3 cycles mid-MAC: same result, 3 cycles later
        do_window(16'h1000, 16'h1000, 16'h1000, 16'h1000, 4'd8, 16'h2000, 1'b1);
        cnt = 0;
        while (req_out !== 1'b1 && cnt < 50) begin
            @(negedge clk);
            cnt++;
            if (cnt == 2) enable = 1'b0;
            if (cnt == 5) enable = 1'b1;
        end
        chk("enable_latency", cnt, 32'd8);
        get_result("enable_gap", 0);

        // Coefficient write during MAC is ignored
        do_window(16'h1000, 16'h1000, 16'h1000, 16'h1000, 4'd9, 16'h2000, 1'b1);
        wr_coef(4'd0, 16'h0000);
        get_result("we_in_mac", 0);
        do_window(16'h1000, 16'h1000, 16'h1000, 16'h1000, 4'd9, 16'h2000, 1'b1);
        get_result("we_in_mac_after", 0);

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
